audio_i2s_tx: RTL and testbench

//  Stereo I2S transmitter (Philips format) that serialises 16-bit signed PCM frames to an external audio DAC.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_bclk_gen.sv | 40 ++++
 rtl/audio_i2s_tx.sv | 108 ++++++++++
 tb/tb_audio_i2s_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared I2S constants and PCM sample types
package audio_pkg;

    localparam int I2S_SLOT_BITS  = 16;
    localparam int I2S_FRAME_BITS = 32;

    typedef logic signed [I2S_SLOT_BITS-1:0] pcm16_t;

    typedef struct packed {
        pcm16_t l;
        pcm16_t r;
    } stereo_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// rtl/audio_bclk_gen.sv - BCLK divider with rise/fall strobes
// Strobes are high in the clk whose edge toggles BCLK, so callers register alongside it.
module audio_bclk_gen #(
    parameter int DIV = 7
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          term;

    always_comb begin
        term   = (div_q == TERM);
        div_d  = term ? '0 : div_q + CW'(1);
        bclk_d = term ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk      = bclk_q;
    assign bclk_rise = term & ~bclk_q;
    assign bclk_fall = term & bclk_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - Philips-format stereo I2S transmitter with one-deep sample buffer
import audio_pkg::*;

module audio_i2s_tx #(
    parameter int DIV = 7
) (
    input  logic                     clk21m,
    input  logic                     reset,
    input  logic [I2S_SLOT_BITS-1:0] pSampleL,
    input  logic [I2S_SLOT_BITS-1:0] pSampleR,
    input  logic                     pSampleValid,
    output logic                     pSampleReady,
    output logic                     pI2sBclk,
    output logic                     pI2sLrck,
    output logic                     pI2sData,
    output logic                     pUnderrun
);

    localparam logic [4:0] RIGHT_SLOT = 5'(I2S_SLOT_BITS);

    logic bclk_fall;
    logic unused_bclk_rise;

    audio_bclk_gen #(.DIV(DIV)) u_bclk_gen (
        .clk       (clk21m),
        .reset     (reset),
        .bclk      (pI2sBclk),
        .bclk_rise (unused_bclk_rise),
        .bclk_fall (bclk_fall)
    );

    logic [4:0]                slot_q, slot_d;
    logic                      lrck_q, lrck_d;
    stereo_t                   hold_q, hold_d;
    logic                      full_q, full_d;
    logic                      ready_q, ready_d;
    logic [I2S_FRAME_BITS-1:0] shift_q, shift_d;
    stereo_t                   last_q, last_d;
    logic                      underrun_q, underrun_d;
    logic                      load;
    logic                      take;

    always_comb begin
        slot_d     = slot_q;
        hold_d     = hold_q;
        full_d     = full_q;
        shift_d    = shift_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        load       = bclk_fall && (slot_q == 5'd0);
        take       = pSampleValid && ready_q;

        if (bclk_fall) begin
            slot_d = slot_q + 5'd1;
            if (load) begin
                // An empty buffer replays the previous frame rather than going silent.
                if (full_q) begin
                    shift_d = hold_q;
                    last_d  = hold_q;
                    full_d  = 1'b0;
                end else begin
                    shift_d    = last_q;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[I2S_FRAME_BITS-2:0], 1'b0};
            end
        end

        // Ready only rises when full is clear, so a capture never collides with a full-buffer load.
        if (take) begin
            hold_d.l = pSampleL;
            hold_d.r = pSampleR;
            full_d   = 1'b1;
        end

        ready_d = ~full_d;
        lrck_d  = (slot_d >= RIGHT_SLOT);
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            slot_q     <= '0;
            lrck_q     <= 1'b0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b0;
            shift_q    <= '0;
            last_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            lrck_q     <= lrck_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    assign pSampleReady = ready_q;
    assign pI2sLrck     = lrck_q;
    assign pI2sData     = shift_q[I2S_FRAME_BITS-1];
    assign pUnderrun    = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - randomized self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;

    localparam int DIV  = 2;
    localparam int BPER = 2 * DIV;

    logic        clk21m = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        underrun;

    audio_i2s_tx #(.DIV(DIV)) dut (
        .clk21m       (clk21m),
        .reset        (reset),
        .pSampleL     (sample_l),
        .pSampleR     (sample_r),
        .pSampleValid (sample_valid),
        .pSampleReady (sample_ready),
        .pI2sBclk     (i2s_bclk),
        .pI2sLrck     (i2s_lrck),
        .pI2sData     (i2s_data),
        .pUnderrun    (underrun)
    );

    always #5 clk21m = ~clk21m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: n = clk edges since reset release; BCLK period = 2*DIV clks,
    // fall number j = n/(2*DIV), slot k = j mod 32, frame load on j mod 32 == 1.
    bit          m_on = 1'b0;
    int unsigned n = 0;
    bit          pend_v = 1'b0;
    logic [31:0] pend = '0;
    logic [31:0] last_f = '0;
    logic [31:0] cur_f = '0;
    logic        m_ready = 1'b0;
    logic        m_und = 1'b0;
    logic        m_bclk = 1'b0;
    logic        m_lrck = 1'b0;
    logic        m_sdata = 1'b0;
    int          k_now = 0;
    bit          acc_evt = 1'b0;
    bit          take = 1'b0;

    always @(posedge clk21m) begin
        acc_evt = 1'b0;
        if (reset) begin
            m_on    = 1'b1;
            n       = 0;
            pend_v  = 1'b0;
            pend    = '0;
            last_f  = '0;
            cur_f   = '0;
            m_ready = 1'b0;
            m_und   = 1'b0;
            k_now   = 0;
        end else if (m_on) begin
            take  = sample_valid && m_ready;
            n     = n + 1;
            m_und = 1'b0;
            if ((n % BPER == 0) && ((n / BPER) % 32 == 1)) begin
                if (pend_v) begin
                    cur_f  = pend;
                    last_f = pend;
                    pend_v = 1'b0;
                end else begin
                    cur_f = last_f;
                    m_und = 1'b1;
                end
            end
            if (take) begin
                pend    = {sample_l, sample_r};
                pend_v  = 1'b1;
                acc_evt = 1'b1;
            end
            m_ready = !pend_v;
            k_now   = (n / BPER) % 32;
        end
        m_bclk  = ((n / DIV) % 2) == 1;
        m_lrck  = (k_now >= 16);
        m_sdata = cur_f[(32 - k_now) % 32];
    end

    logic [31:0] col = '0;
    int          col_n = 0;
    logic        prev_bclk = 1'b0;

    always @(negedge clk21m) begin
        if (m_on) begin
            check_eq("bclk", 32'(i2s_bclk), 32'(m_bclk));
            check_eq("lrck", 32'(i2s_lrck), 32'(m_lrck));
            check_eq("sdata", 32'(i2s_data), 32'(m_sdata));
            check_eq("ready", 32'(sample_ready), 32'(m_ready));
            check_eq("underrun", 32'(underrun), 32'(m_und));
            if (reset) begin
                col_n = 0;
            end else if (m_bclk && !prev_bclk) begin
                // Bits sampled on BCLK rises from k=1 through k=0 rebuild {L,R}.
                if (k_now == 1) begin
                    col   = {31'b0, i2s_data};
                    col_n = 1;
                end else begin
                    col   = {col[30:0], i2s_data};
                    col_n = col_n + 1;
                end
                if (k_now == 0 && col_n == 32)
                    check_eq("frame", col, cur_f);
            end
            prev_bclk = m_bclk;
        end
    end

    task automatic tick();
        @(posedge clk21m);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bit got;
        got          = 1'b0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            got = acc_evt;
        end
        sample_valid = 1'b0;
        check_eq("accept", 32'(got), 32'd1);
    endtask

    task automatic wait_before_load();
        for (int i = 0; i < 2000; i++) begin
            if (((n + 1) % BPER == 0) && (((n + 1) / BPER) % 32 == 1)) break;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;

        send(16'hA5F0, 16'h0F0F);
        send(16'h1234, 16'hFEDC);
        repeat (3 * 32 * BPER) tick();

        send(16'h5A5A, 16'hC3C3);
        for (int i = 0; i < 2000 && k_now != 20; i++) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        tick();
        wait_before_load();
        sample_l     = 16'h8000;
        sample_r     = 16'h7FFF;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_eq("edge_accept", 32'(acc_evt), 32'd1);
        repeat (2 * 32 * BPER + 4) tick();

        for (int c = 0; c < 3000; c++) begin
            sample_valid = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                sample_l = 16'h8000;
                sample_r = 16'h7FFF;
            end else begin
                sample_l = 16'($urandom);
                sample_r = 16'($urandom);
            end
            reset = ($urandom_range(0, 1499) == 0);
            tick();
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
        repeat (40 * BPER) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
